// File: rtl/udiv_pkg.sv
// Shared definitions for the iterative unsigned restoring divider.
//   state_t : control FSM encoding (IDLE, CALC, DONE)
//   clog2   : ceiling log2, used to size the iteration counter
package udiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        for (int k = 0; k < 32; k++) begin
            if (remaining > 0) begin
                result    = result + 1;
                remaining = remaining >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/top_udiv_7ns_5ns_seq_udiv_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
//   p       : current partial remainder (D+1 bits)
//   din_bit : dividend bit consumed by this iteration
//   divisor : divisor (D bits)
//   p_next  : partial remainder after the iteration
//   q_bit   : quotient bit produced by the iteration
module udiv_step
    import udiv_pkg::*;
#(
    parameter int D = 5
) (
    input  logic [D:0]   p,
    input  logic         din_bit,
    input  logic [D-1:0] divisor,
    output logic [D:0]   p_next,
    output logic         q_bit
);

    logic [D:0] p_shift;
    logic [D:0] div_ext;

    // The partial remainder is always below the divisor, so its top bit is
    // zero and shifting it out of the D+1-bit window loses nothing.
    always_comb begin
        p_shift = (p << 1) | {{D{1'b0}}, din_bit};
        div_ext = {1'b0, divisor};
        if (p_shift >= div_ext) begin
            p_next = p_shift - div_ext;
            q_bit  = 1'b1;
        end else begin
            p_next = p_shift;
            q_bit  = 1'b0;
        end
    end

endmodule

// File: rtl/top_udiv_7ns_5ns_seq.sv
// Iterative unsigned restoring divider, one quotient bit per enabled clock,
// with an ap_start/ap_done block handshake and an ap_ce stall.
//   ap_clk, ap_rst_n : clock, synchronous active-low reset
//   ap_ce            : clock enable, low freezes everything except reset
//   ap_start         : request; din0/din1 latched when accepted
//   ap_ready         : request accepted this cycle
//   ap_idle          : block is idle
//   ap_done          : quot/rem valid (one enabled cycle)
//   din0, din1       : dividend (W bits), divisor (D bits)
//   quot, rem        : quotient (W bits), remainder (D bits), held
module top_udiv_7ns_5ns_seq
    import udiv_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 7,
    parameter int din1_WIDTH = 5
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_ce,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [din0_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem
);

    localparam int W     = din0_WIDTH;
    localparam int D     = din1_WIDTH;
    localparam int CNT_W = clog2(W + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [D:0]       p_q,     p_d;
    logic [W-1:0]     acc_q,   acc_d;
    logic [D-1:0]     div_q,   div_d;
    logic [W-1:0]     quot_q,  quot_d;
    logic [D-1:0]     rem_q,   rem_d;

    logic [D:0]       step_p;
    logic             step_q;
    logic             can_accept;

    // acc_q starts as the dividend; each iteration shifts its MSB into the
    // partial remainder and shifts the new quotient bit into its LSB, so after
    // W iterations it holds the full quotient.
    udiv_step #(
        .D(D)
    ) u_step (
        .p      (p_q),
        .din_bit(acc_q[W-1]),
        .divisor(div_q),
        .p_next (step_p),
        .q_bit  (step_q)
    );

    assign can_accept = (state_q == IDLE) || (state_q == DONE);
    assign ap_ready   = can_accept && ap_start && ap_ce;
    assign ap_idle    = (state_q == IDLE);
    assign ap_done    = (state_q == DONE);
    assign quot       = quot_q;
    assign rem        = rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        acc_d   = acc_q;
        div_d   = div_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        case (state_q)
            IDLE, DONE: begin
                if (ap_start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    p_d     = '0;
                    acc_d   = din0;
                    div_d   = din1;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                p_d   = step_p;
                acc_d = {acc_q[W-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d = DONE;
                    quot_d  = {acc_q[W-2:0], step_q};
                    rem_d   = step_p[D-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset wins over ap_ce; otherwise ap_ce gates every register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else if (ap_ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_top_udiv_7ns_5ns_seq.sv
// Directed self-checking bench for top_udiv_7ns_5ns_seq.
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge of the same cycle.
module tb_top_udiv_7ns_5ns_seq;

    logic       ap_clk;
    logic       ap_rst_n;
    logic       ap_ce;
    logic       ap_start;
    logic       ap_ready;
    logic       ap_idle;
    logic       ap_done;
    logic [6:0] din0;
    logic [4:0] din1;
    logic [6:0] quot;
    logic [4:0] rem;

    int vectors;
    int miscompares;

    top_udiv_7ns_5ns_seq #(
        .ID        (1),
        .din0_WIDTH(7),
        .din1_WIDTH(5)
    ) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .ap_ce   (ap_ce),
        .ap_start(ap_start),
        .ap_ready(ap_ready),
        .ap_idle (ap_idle),
        .ap_done (ap_done),
        .din0    (din0),
        .din1    (din1),
        .quot    (quot),
        .rem     (rem)
    );

    // 10ns clock, first rising edge at 5ns.
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    // Drive one cycle's inputs, then wait for the sampling point.
    task automatic applyStimulus(input logic start, input logic ce, input logic rst_n,
                                 input logic [6:0] a, input logic [4:0] b);
        ap_start = start;
        ap_ce    = ce;
        ap_rst_n = rst_n;
        din0     = a;
        din1     = b;
        @(negedge ap_clk);
    endtask

    // Move past the next rising edge so the next cycle can be driven.
    task automatic finishCycle();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Cycle 0 of an operation: request with operands, must be accepted.
    task automatic acceptOp(input logic [6:0] a, input logic [4:0] b, input string tag);
        applyStimulus(1'b1, 1'b1, 1'b1, a, b);
        checkOutput({tag, " ready"}, 32'(ap_ready), 32'd1);
        finishCycle();
    endtask

    // Cycles 1..exp_lat of an accepted operation. ap_ce is low for stall_len
    // cycles from stall_at; ap_start is pulsed at pulse_at (must be ignored);
    // with chain set, the next request na/nb is presented in the done cycle.
    // done_hold ce-low cycles after the done cycle check that ap_done stretches.
    task automatic waitDone(input int exp_lat, input int stall_at, input int stall_len,
                            input int pulse_at, input logic chain,
                            input logic [6:0] na, input logic [4:0] nb,
                            input logic [6:0] exp_q, input logic [4:0] exp_r,
                            input int done_hold, input string tag);
        logic start;
        logic ce;
        for (int c = 1; c <= exp_lat; c++) begin
            ce    = !((c >= stall_at) && (c < stall_at + stall_len));
            start = (c == pulse_at) || (chain && (c == exp_lat));
            if ((c == exp_lat) && (done_hold > 0)) ce = 1'b0;
            applyStimulus(start, ce, 1'b1, na, nb);
            if (c == 1) checkOutput({tag, " busy idle"}, 32'(ap_idle), 32'd0);
            if (c == pulse_at) checkOutput({tag, " busy ready"}, 32'(ap_ready), 32'd0);
            if (c < exp_lat) begin
                checkOutput({tag, " early done"}, 32'(ap_done), 32'd0);
            end else begin
                checkOutput({tag, " done"}, 32'(ap_done), 32'd1);
                checkOutput({tag, " quot"}, 32'(quot), 32'(exp_q));
                checkOutput({tag, " rem"}, 32'(rem), 32'(exp_r));
                if (chain) checkOutput({tag, " chain ready"}, 32'(ap_ready), 32'd1);
            end
            finishCycle();
        end
        for (int h = 1; h <= done_hold; h++) begin
            applyStimulus(1'b0, (h == done_hold), 1'b1, na, nb);
            checkOutput({tag, " done held"}, 32'(ap_done), 32'd1);
            finishCycle();
        end
    endtask

    task automatic checkIdle(input string tag);
        applyStimulus(1'b0, 1'b1, 1'b1, 7'd0, 5'd0);
        checkOutput({tag, " idle"}, 32'(ap_idle), 32'd1);
        checkOutput({tag, " no done"}, 32'(ap_done), 32'd0);
        finishCycle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset for three cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 7'd0, 5'd0);
            finishCycle();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 7'd0, 5'd0);
        checkOutput("reset idle", 32'(ap_idle), 32'd1);
        checkOutput("reset done", 32'(ap_done), 32'd0);
        checkOutput("reset ready", 32'(ap_ready), 32'd0);
        checkOutput("reset quot", 32'(quot), 32'd0);
        checkOutput("reset rem", 32'(rem), 32'd0);
        finishCycle();

        // Basic: 89 / 13 = 6 remainder 11, done in cycle 8.
        acceptOp(7'd89, 5'd13, "basic");
        waitDone(8, 0, 0, 0, 1'b0, 7'd127, 5'd31, 7'd6, 5'd11, 0, "basic");
        checkIdle("basic after");

        // Multiplier round trip: (a*b) / b = a remainder 0.
        for (int a = 0; a <= 7; a++) begin
            for (int b = 1; b <= 31; b++) begin
                if (a * b <= 127) begin
                    acceptOp(7'(a * b), 5'(b), "roundtrip");
                    waitDone(8, 0, 0, 0, 1'b0, 7'd0, 5'd0, 7'(a), 5'd0, 0, "roundtrip");
                end
            end
        end
        acceptOp(7'd127, 5'd1, "max by one");
        waitDone(8, 0, 0, 0, 1'b0, 7'd0, 5'd0, 7'd127, 5'd0, 0, "max by one");

        // Divide by zero: quotient all ones, remainder 100 mod 32 = 4.
        // ap_ce is held low in and after the done cycle, so ap_done stretches.
        acceptOp(7'd100, 5'd0, "div zero");
        waitDone(8, 0, 0, 0, 1'b0, 7'd0, 5'd0, 7'd127, 5'd4, 2, "div zero");
        checkIdle("div zero after");

        // Stall: ce low cycles 3..5, start pulse in cycle 2 ignored, done at 11.
        acceptOp(7'd89, 5'd13, "stall");
        waitDone(11, 3, 3, 2, 1'b0, 7'd50, 5'd7, 7'd6, 5'd11, 0, "stall");
        checkIdle("stall after 1");
        checkIdle("stall after 2");

        // Back to back: 50 / 7 = 7 remainder 1 accepted in the done cycle.
        acceptOp(7'd89, 5'd13, "b2b first");
        waitDone(8, 0, 0, 0, 1'b1, 7'd50, 5'd7, 7'd6, 5'd11, 0, "b2b first");
        waitDone(8, 0, 0, 0, 1'b0, 7'd0, 5'd0, 7'd7, 5'd1, 0, "b2b second");
        checkIdle("b2b after");

        // Reset in cycle 4 of an operation, with ap_ce low to show reset wins.
        acceptOp(7'd100, 5'd3, "abort");
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 7'd0, 5'd0);
            finishCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 5'd0);
        finishCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 7'd0, 5'd0);
        checkOutput("abort quot", 32'(quot), 32'd0);
        checkOutput("abort rem", 32'(rem), 32'd0);
        finishCycle();
        for (int c = 0; c < 10; c++) begin
            checkIdle("abort");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
